// File: rtl/mult_div_unit.sv
// Iterative MIPS32 multiply/divide unit: 32-step shift-add multiply and restoring divide into HI/LO.
// Build option: define MDU_DIV_EN to include DIV/DIVU and div_by_zero; without it only MULT/MULTU/MTHI/MTLO exist.
module mult_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [5:0]      funct,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  function automatic logic [XLEN-1:0] to_mag(input logic signed [XLEN-1:0] v, input logic is_signed);
    return (is_signed && (v < 0)) ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] sign_fix_w2(input logic [2*XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

`ifdef MDU_DIV_EN
  function automatic logic [XLEN-1:0] sign_fix_w(input logic [XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction
`endif

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [XLEN-1:0]     hi_q, lo_q;
  logic [2*XLEN-1:0]   acc_q;
  logic [XLEN-1:0]     opb_q;
  logic                neg_lo_q;

  logic                is_mul, is_div, signed_op, can_issue, accept, last_step;
  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_next, acc_next, prod;
  logic [XLEN-1:0]     hi_res, lo_res;

  // Issue decode: a new op is only taken outside RUN
  assign is_mul    = (funct == F_MULT) || (funct == F_MULTU);
`ifdef MDU_DIV_EN
  assign is_div    = (funct == F_DIV) || (funct == F_DIVU);
`else
  assign is_div    = 1'b0;
`endif
  assign signed_op = (funct == F_MULT) || (funct == F_DIV);
  assign can_issue = start && (state_q != S_RUN);
  assign accept    = can_issue && (is_mul || is_div);
  assign last_step = (cnt_q == CNT_W'(XLEN - 1));

  // acc_q holds {upper, multiplier} for multiply; {remainder, dividend/quotient} for divide
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};
  assign prod     = sign_fix_w2(mul_next, neg_lo_q);

`ifdef MDU_DIV_EN
  logic              op_div_q, neg_hi_q, dbz_q;
  logic [XLEN:0]     rem_sh;
  logic              div_ge;
  logic [XLEN-1:0]   rem_new;
  logic [2*XLEN-1:0] div_next;
  logic              dbz_res;

  assign rem_sh   = acc_q[2*XLEN-1:XLEN-1];
  assign div_ge   = rem_sh >= {1'b0, opb_q};
  assign rem_new  = div_ge ? (rem_sh[XLEN-1:0] - opb_q) : rem_sh[XLEN-1:0];
  assign div_next = {rem_new, acc_q[XLEN-2:0], div_ge};
  assign acc_next = op_div_q ? div_next : mul_next;
  assign dbz_res  = op_div_q && (opb_q == '0);
`else
  assign acc_next = mul_next;
`endif

  // Completion fix-up; a zero divisor leaves |dividend| as remainder, so re-signing restores srcA
  always_comb begin
    hi_res = prod[2*XLEN-1:XLEN];
    lo_res = prod[XLEN-1:0];
`ifdef MDU_DIV_EN
    if (op_div_q) begin
      hi_res = sign_fix_w(div_next[2*XLEN-1:XLEN], neg_hi_q);
      lo_res = (opb_q == '0) ? '1 : sign_fix_w(div_next[XLEN-1:0], neg_lo_q);
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: state_d = accept ? S_RUN : S_IDLE;
      S_RUN:          if (last_step) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
`ifdef MDU_DIV_EN
      dbz_q <= 1'b0;
`endif
    end else begin
      if (accept)                 cnt_q <= '0;
      else if (state_q == S_RUN)  cnt_q <= cnt_q + 1'b1;

      if ((state_q == S_RUN) && last_step) begin
        hi_q  <= hi_res;
        lo_q  <= lo_res;
`ifdef MDU_DIV_EN
        dbz_q <= dbz_res;
`endif
      end else if (can_issue && (funct == F_MTHI)) begin
        hi_q <= srcA;
      end else if (can_issue && (funct == F_MTLO)) begin
        lo_q <= srcA;
      end
    end
  end

  // Operand latch and iteration datapath; no reset needed on data
  always_ff @(posedge clk) begin
    if (accept) begin
      acc_q    <= {{XLEN{1'b0}}, to_mag(srcA, signed_op)};
      opb_q    <= to_mag(srcB, signed_op);
      neg_lo_q <= signed_op && (srcA[XLEN-1] ^ srcB[XLEN-1]);
`ifdef MDU_DIV_EN
      op_div_q <= is_div;
      neg_hi_q <= signed_op && srcA[XLEN-1];
`endif
    end else if (state_q == S_RUN) begin
      acc_q <= acc_next;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;
`ifdef MDU_DIV_EN
  assign div_by_zero = done && dbz_q;
`else
  assign div_by_zero = 1'b0;
`endif

endmodule
